// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures imem output into the IF/ID register.
// Optional fetch/stall counters are enabled with `define FETCH_STATS_EN.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic        halted,
    output logic        fault
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_stalls
`endif
);

    localparam logic [63:0] LAST_PC = 64'(MEM_BYTES) - 64'd4;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] pc;
    } ifid_t;

    state_t      state, state_n;
    ifid_t       ifid_q, ifid_d;
    logic [63:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic        accept, redir_ok, capture;

    assign accept   = !ifid_q.valid || id_ready;
    assign redir_ok = (redirect_pc[1:0] == 2'b00) && !(redirect_pc > LAST_PC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        ifid_d  = ifid_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        capture = 1'b0;
        case (state)
            IDLE: state_n = RUN;
            RUN: begin
                if (redirect_valid && redir_ok) begin
                    pc_d         = redirect_pc;
                    ifid_d.valid = 1'b0;
                end else if (redirect_valid) begin
                    ifid_d.valid = 1'b0;
                    fault_d      = 1'b1;
                    state_n      = HALT;
                end else if (accept) begin
                    capture      = 1'b1;
                    ifid_d.valid = 1'b1;
                    ifid_d.instr = imem_instr;
                    ifid_d.pc    = pc_q;
                    // last word of memory: park the PC, no wrap-around
                    if (pc_q == LAST_PC) state_n = HALT;
                    else                 pc_d    = pc_q + 64'd4;
                end
            end
            HALT: begin
                if (id_ready) ifid_d.valid = 1'b0;
                if (redirect_valid && redir_ok) begin
                    pc_d         = redirect_pc;
                    ifid_d.valid = 1'b0;
                    state_n      = RUN;
                end else if (redirect_valid) begin
                    fault_d = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q  <= '0;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            ifid_q  <= ifid_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign imem_pc  = pc_q;
    assign if_valid = ifid_q.valid;
    assign if_instr = ifid_q.instr;
    assign if_pc    = ifid_q.pc;
    assign fault    = fault_q;
    assign halted   = (state == HALT);

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q, stalls_q;
    logic        stall_cyc;

    assign stall_cyc = (state == RUN) && ifid_q.valid && !id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (capture && fetched_q != 32'hFFFF_FFFF)  fetched_q <= fetched_q + 32'd1;
            if (stall_cyc && stalls_q != 32'hFFFF_FFFF) stalls_q  <= stalls_q + 32'd1;
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_stalls  = stalls_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Table-driven bench for if_fetch_stage with a combinational imem model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        halted;
    logic        fault;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_stalls;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return {8'hA5, pc[7:0], ~pc[7:0], 8'h5A};
    endfunction

    assign imem_instr = instr_of(imem_pc);

    if_fetch_stage #(.RESET_PC(64'h0), .MEM_BYTES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_pc(imem_pc), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .halted(halted), .fault(fault)
`ifdef FETCH_STATS_EN
        , .stat_fetched(stat_fetched), .stat_stalls(stat_stalls)
`endif
    );

    typedef struct {
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        ev;
        logic [63:0] epc;
        logic [63:0] eimem;
        logic        eh;
        logic        ef;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rv, input logic [63:0] rpc, input logic rdy,
                       input logic ev, input logic [63:0] epc, input logic [63:0] eimem,
                       input logic eh, input logic ef);
        vec_t v;
        v = '{rv, rpc, rdy, ev, epc, eimem, eh, ef};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input vec_t v);
        chk({tag, ".valid"}, 64'(if_valid), 64'(v.ev));
        chk({tag, ".imem_pc"}, imem_pc, v.eimem);
        chk({tag, ".halted"}, 64'(halted), 64'(v.eh));
        chk({tag, ".fault"}, 64'(fault), 64'(v.ef));
        if (v.ev) begin
            chk({tag, ".if_pc"}, if_pc, v.epc);
            chk({tag, ".if_instr"}, 64'(if_instr), 64'(instr_of(v.epc)));
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        id_ready       = v.rdy;
        @(posedge clk);
        #1;
        check_state(tag, v);
    endtask

    initial begin
        vec_t h;

        // streaming from reset to the end of memory
        add(0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++)
            add(0, 0, 1, 1, 64'(4 * k), (k == 15) ? 64'd60 : 64'(4 * k + 4), k == 15, 0);
        add(0, 0, 0, 1, 60, 60, 1, 0);
        add(0, 0, 1, 0, 0, 60, 1, 0);
        // resume, then stall at if_pc=8
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 1, 1, 64'(4 * k), 64'(4 * k + 4), 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 1, 8, 12, 0, 0);
        add(0, 0, 1, 1, 12, 16, 0, 0);
        add(0, 0, 1, 1, 16, 20, 0, 0);
        // legal redirect with decode stalled
        add(1, 40, 0, 0, 0, 40, 0, 0);
        add(0, 0, 1, 1, 40, 44, 0, 0);
        add(0, 0, 1, 1, 44, 48, 0, 0);
        // misaligned, then out-of-range redirect
        add(1, 42, 1, 0, 0, 48, 1, 1);
        add(0, 0, 0, 0, 0, 48, 1, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 4, 0, 1);
        add(1, 64, 0, 0, 0, 4, 1, 1);
        add(1, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 4, 0, 1);
        // redirect wins over a simultaneous drain
        add(1, 20, 1, 0, 0, 20, 0, 1);
        add(0, 0, 1, 1, 20, 24, 0, 1);

        #2;
        chk("reset.valid", 64'(if_valid), 0);
        chk("reset.imem_pc", imem_pc, 0);
        chk("reset.if_pc", if_pc, 0);
        chk("reset.if_instr", 64'(if_instr), 0);
        chk("reset.halted", 64'(halted), 0);
        chk("reset.fault", 64'(fault), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) step($sformatf("v%0d", i), vecs[i]);

`ifdef FETCH_STATS_EN
        chk("stat_fetched", 64'(stat_fetched), 26);
        chk("stat_stalls", 64'(stat_stalls), 5);
`endif

        // asynchronous reset between edges with imem_pc=24
        #3 rst_n = 1'b0;
        #1;
        h = '{0, 0, 1, 0, 0, 0, 0, 0};
        check_state("areset", h);
        chk("areset.if_pc", if_pc, 0);
        chk("areset.if_instr", 64'(if_instr), 0);
`ifdef FETCH_STATS_EN
        chk("areset.stat_fetched", 64'(stat_fetched), 0);
        chk("areset.stat_stalls", 64'(stat_stalls), 0);
`endif
        @(posedge clk);
        #1;
        check_state("areset.hold", h);
        rst_n = 1'b1;
        step("rel.idle", h);
        h = '{0, 0, 1, 1, 0, 4, 0, 0};
        step("rel.pc0", h);
        h = '{0, 0, 1, 1, 4, 8, 0, 0};
        step("rel.pc4", h);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the combinational instruction memory (imem) and downstream of the branch-resolution logic.
- Owns the 64-bit byte-addressed PC and drives it to imem. Captures the returned 32-bit instruction into an IF/ID pipeline register with a valid/ready handshake toward decode.
- Handles branch redirect/flush, decode back-pressure and end-of-memory halt.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- MEM_BYTES, 64, size of the instruction memory in bytes; must be a multiple of 4.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_pc  output  64  byte address presented to imem; equals the internal PC register.
- imem_instr  input  32  instruction returned by imem, combinational from imem_pc in the same cycle.
- redirect_valid  input  1  branch/jump taken; load redirect_pc.
- redirect_pc  input  64  target byte address.
- id_ready  input  1  decode accepts the IF/ID contents this cycle.
- if_valid  output  1  IF/ID register holds a valid instruction.
- if_instr  output  32  registered instruction.
- if_pc  output  64  PC of if_instr.
- halted  output  1  fetch stopped (state HALT).
- fault  output  1  sticky; set by a misaligned or out-of-range redirect.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - PC=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, fault=0, state=IDLE.
  - Applies immediately, including mid-operation; any in-flight IF/ID contents are discarded.
- State machine, three states:
  - IDLE: one cycle after rst_n deasserts. No capture. Next state is RUN.
  - RUN: fetching.
  - HALT: fetch stopped; halted=1 combinationally from state.
- Accept condition: accept = !if_valid || id_ready (IF/ID register empty or being drained).
- RUN, priority order:
  1. redirect_valid=1 with redirect_pc[1:0]==0 and redirect_pc <= MEM_BYTES-4: PC<=redirect_pc; if_valid<=0 (flush), regardless of id_ready; stay in RUN.
  2. redirect_valid=1 with a misaligned or out-of-range target: if_valid<=0, fault<=1, PC unchanged, go to HALT.
  3. accept=1: if_instr<=imem_instr, if_pc<=PC, if_valid<=1.
     - If PC==MEM_BYTES-4, PC is unchanged and state goes to HALT. There is no wrap-around.
     - Otherwise PC<=PC+4.
  4. Otherwise (stall): PC, if_instr, if_pc and if_valid all hold.
- HALT:
  - No new capture.
  - id_ready=1 with if_valid=1 gives if_valid<=0 (drain).
  - A legal redirect sets PC<=redirect_pc, if_valid<=0 and goes to RUN; fault remains as it was.
  - An illegal redirect leaves the state in HALT and sets fault<=1.
- Latency and throughput: an instruction is visible on if_instr one clock after its PC is on imem_pc. Throughput is one instruction per clock while id_ready=1.
- Redirect and handshake together: a redirect coinciding with id_ready=1 still flushes; decode must ignore the flushed slot. Redirect has priority over capture in the same cycle.
- Arithmetic: PC+4 is computed in full 64-bit width. The range check uses the unsigned 64-bit compare redirect_pc > MEM_BYTES-4.
- if_instr/if_pc values while if_valid=0 are don't-care for decode. The bench checks them only when if_valid=1.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: adds two output ports.
  - stat_fetched[31:0]: increments on every capture (accept in RUN).
  - stat_stalls[31:0]: increments on every RUN cycle with if_valid=1 and id_ready=0.
  - Both counters reset to 0 asynchronously, saturate at 32'hFFFFFFFF and are unaffected by redirects.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Streaming: reset, id_ready=1 constantly.
  - IDLE, then if_pc follows 0,4,8,…,60 on consecutive cycles with if_instr equal to imem contents.
  - After capturing PC 60, halted=1 with PC=60; if_valid drops to 0 the cycle after.
- Stall: drop id_ready for 3 cycles while if_pc=8.
  - if_pc=8, if_instr and imem_pc=12 hold for 3 cycles.
  - Next capture is PC 12 after id_ready returns. With FETCH_STATS_EN, stat_stalls=3.
- Redirect: redirect_valid=1, redirect_pc=40 while if_pc=16, id_ready=0.
  - Next cycle if_valid=0 and imem_pc=40.
  - The following cycle if_pc=40.
- Illegal redirect: redirect_pc=42, then separately redirect_pc=64.
  - Each gives fault=1, halted=1, if_valid=0 and PC unchanged.
  - A later redirect to 0 resumes fetch with fault still 1.
- Async reset mid-run: assert rst_n=0 between clock edges at PC=24.
  - Outputs go to their reset values immediately: if_valid=0, imem_pc=RESET_PC.
  - After release, one IDLE cycle, then fetch restarts from RESET_PC.
